// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_unit_pkg;
  localparam int          STALL_WD_DEF = 6;
  localparam int          IF_TO_ID_WD  = 33;
  localparam int          BR_WD        = 33;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFBF_FFFC;
  localparam logic        STOP         = 1'b1;
  localparam logic        NO_STOP      = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD
  } fetch_state_e;
endpackage

// File: rtl/if_inst_buf.sv
// Holds the fetched instruction word while decode is stalled.
module if_inst_buf (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        capture_i,
  input  logic        release_i,
  input  logic [31:0] din_i,
  output logic [31:0] dout_o,
  output logic        valid_o
);
  logic        valid_q, valid_d;
  logic [31:0] buf_q, buf_d;

  always_comb begin
    valid_d = valid_q;
    buf_d   = buf_q;
    if (release_i) begin
      valid_d = 1'b0;
    end else if (capture_i && !valid_q) begin
      valid_d = 1'b1;
      buf_d   = din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) valid_q <= 1'b0;
    else        valid_q <= valid_d;
    buf_q <= buf_d;
  end

  assign dout_o  = buf_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction SRAM and
// feeds decode with {ce, pc} plus a word that stays stable across ID stalls.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int          STALL_WD = STALL_WD_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [STALL_WD-1:0]    stall,
  input  logic [BR_WD-1:0]       br_bus,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus,
  output logic [31:0]            fetch_inst,
  output logic                   inst_sram_en,
  output logic [3:0]             inst_sram_wen,
  output logic [31:0]            inst_sram_addr,
  output logic [31:0]            inst_sram_wdata,
  input  logic [31:0]            inst_sram_rdata
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_v_q, pend_v_d;
  logic [31:0]  pend_addr_q, pend_addr_d;
  logic [31:0]  next_pc;
  logic         br_e, if_go, ce_act;
  logic [31:0]  br_addr;
  logic [31:0]  buf_dout;
  logic         buf_valid;
  logic         unused_stall;

  assign br_e         = br_bus[32];
  assign br_addr      = br_bus[31:0];
  assign if_go        = (stall[0] == NO_STOP);
  assign unused_stall = ^stall[STALL_WD-1:2];

  // A live redirect beats a parked one; both beat sequential fetch.
  always_comb begin
    if (br_e)          next_pc = br_addr;
    else if (pend_v_q) next_pc = pend_addr_q;
    else               next_pc = pc_q + 32'd4;
  end

  always_comb begin
    pc_d        = pc_q;
    pend_v_d    = pend_v_q;
    pend_addr_d = pend_addr_q;
    if (if_go) begin
      pc_d     = next_pc;
      pend_v_d = 1'b0;
    end else if (br_e) begin
      pend_v_d    = 1'b1;
      pend_addr_d = br_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (if_go)              state_d = S_RUN;
      S_RUN:   if (stall[1] == STOP)    state_d = S_HOLD;
      S_HOLD:  if (stall[1] == NO_STOP) state_d = S_RUN;
      default:                          state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      pend_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pend_v_q <= pend_v_d;
    end
    pend_addr_q <= pend_addr_d;
  end

  if_inst_buf u_inst_buf (
    .clk_i     (clk),
    .rst_i     (rst),
    .capture_i (stall[1] == STOP),
    .release_i (stall[1] == NO_STOP),
    .din_i     (fetch_inst),
    .dout_o    (buf_dout),
    .valid_o   (buf_valid)
  );

  // Outputs are forced to their reset view while rst is low, independent of state.
  assign ce_act          = rst & (state_q != S_IDLE);
  assign fetch_inst      = ce_act ? (buf_valid ? buf_dout : inst_sram_rdata) : 32'b0;
  assign if_to_id_bus    = {ce_act, (rst ? pc_q : RESET_PC)};
  assign inst_sram_en    = rst & if_go;
  assign inst_sram_addr  = next_pc;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'b0;
endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit with a one-cycle-latency SRAM model.
module tb_if_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic [32:0] br_bus;
  logic [32:0] if_to_id_bus;
  logic [31:0] fetch_inst;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata = 32'b0;

  logic        ovr_en  = 1'b0;
  logic [31:0] ovr_val = 32'b0;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } exp_t;
  exp_t sb[$];

  if_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .br_bus          (br_bus),
    .if_to_id_bus    (if_to_id_bus),
    .fetch_inst      (fetch_inst),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h1234_5678;
  endfunction

  always @(posedge clk) begin
    if (ovr_en)            inst_sram_rdata <= ovr_val;
    else if (inst_sram_en) inst_sram_rdata <= mem_word(inst_sram_addr);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One unstalled cycle: request checked and pushed before the edge, delivery popped after it.
  task automatic fetch_cycle(input logic [31:0] exp_addr);
    exp_t e;
    #1;
    chk("sram_en", 64'(inst_sram_en), 64'(1'b1));
    chk("sram_addr", 64'(inst_sram_addr), 64'(exp_addr));
    chk("sram_wen", 64'(inst_sram_wen), 64'(4'b0));
    sb.push_back('{addr: exp_addr, inst: (ovr_en ? ovr_val : mem_word(exp_addr))});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_underflow", 64'(0), 64'(1));
    end else begin
      e = sb.pop_front();
      chk("ce", 64'(if_to_id_bus[32]), 64'(1'b1));
      chk("pc", 64'(if_to_id_bus[31:0]), 64'(e.addr));
      chk("inst", 64'(fetch_inst), 64'(e.inst));
    end
    @(negedge clk);
  endtask

  task automatic stall_cycle(input logic [31:0] exp_pc, input logic [31:0] exp_inst);
    #1;
    chk("stall_en", 64'(inst_sram_en), 64'(1'b0));
    chk("stall_pc", 64'(if_to_id_bus[31:0]), 64'(exp_pc));
    chk("stall_inst", 64'(fetch_inst), 64'(exp_inst));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0; stall = 6'b0; br_bus = 33'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_en", 64'(inst_sram_en), 64'(1'b0));
    chk("rst_inst", 64'(fetch_inst), 64'(32'b0));
    chk("rst_bus", 64'(if_to_id_bus), 64'({1'b0, 32'hBFBF_FFFC}));

    // Reset release, sequential fetch
    rst = 1'b1;
    #1 chk("ce_pre", 64'(if_to_id_bus[32]), 64'(1'b0));
    fetch_cycle(32'hBFC0_0000);
    fetch_cycle(32'hBFC0_0004);
    fetch_cycle(32'hBFC0_0008);

    // One-cycle redirect; delay-slot word still presented this cycle
    br_bus = {1'b1, 32'h8000_0100};
    #1 chk("dslot_pc", 64'(if_to_id_bus[31:0]), 64'(32'hBFC0_0008));
    chk("dslot_inst", 64'(fetch_inst), 64'(mem_word(32'hBFC0_0008)));
    fetch_cycle(32'h8000_0100);
    br_bus = 33'b0;
    fetch_cycle(32'h8000_0104);

    // Full stall with redirect raised mid-stall
    stall = 6'b000011;
    stall_cycle(32'h8000_0104, mem_word(32'h8000_0104));
    br_bus = {1'b1, 32'h8000_0200};
    stall_cycle(32'h8000_0104, mem_word(32'h8000_0104));
    br_bus = 33'b0;
    #1 chk("pend_addr", 64'(inst_sram_addr), 64'(32'h8000_0200));
    stall_cycle(32'h8000_0104, mem_word(32'h8000_0104));
    stall = 6'b0;
    fetch_cycle(32'h8000_0200);
    fetch_cycle(32'h8000_0204);

    // ID stall holds the word while SRAM data changes underneath
    ovr_en = 1'b1; ovr_val = 32'hDEAD_BEEF;
    fetch_cycle(32'h8000_0208);
    stall = 6'b000011; ovr_val = 32'h0BAD_F00D;
    stall_cycle(32'h8000_0208, 32'hDEAD_BEEF);
    stall_cycle(32'h8000_0208, 32'hDEAD_BEEF);
    #1 chk("hold_rdata", 64'(fetch_inst), 64'(32'hDEAD_BEEF));
    stall = 6'b0;
    fetch_cycle(32'h8000_020C);
    ovr_en = 1'b0;
    fetch_cycle(32'h8000_0210);

    // Last redirect during a stall wins; live redirect on release beats the parked one
    stall = 6'b000011;
    br_bus = {1'b1, 32'h8000_0380};
    stall_cycle(32'h8000_0210, mem_word(32'h8000_0210));
    br_bus = {1'b1, 32'h8000_0400};
    stall_cycle(32'h8000_0210, mem_word(32'h8000_0210));
    br_bus = 33'b0;
    #1 chk("last_wins", 64'(inst_sram_addr), 64'(32'h8000_0400));
    stall = 6'b0;
    br_bus = {1'b1, 32'h8000_0500};
    fetch_cycle(32'h8000_0500);
    br_bus = 33'b0;
    fetch_cycle(32'h8000_0504);

    // Reset mid-stall with a parked redirect
    stall = 6'b000011;
    br_bus = {1'b1, 32'h8000_0300};
    stall_cycle(32'h8000_0504, mem_word(32'h8000_0504));
    br_bus = 33'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst2_bus", 64'(if_to_id_bus), 64'({1'b0, 32'hBFBF_FFFC}));
    chk("rst2_en", 64'(inst_sram_en), 64'(1'b0));
    chk("rst2_inst", 64'(fetch_inst), 64'(32'b0));
    rst = 1'b1; stall = 6'b0;
    fetch_cycle(32'hBFC0_0000);
    fetch_cycle(32'hBFC0_0004);

    // PC wrap-around
    br_bus = {1'b1, 32'hFFFF_FFFC};
    fetch_cycle(32'hFFFF_FFFC);
    br_bus = 33'b0;
    fetch_cycle(32'h0000_0000);
    fetch_cycle(32'h0000_0004);

    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
